// File: rtl/control_flow_monitor.sv
// Runtime checker for control-flow redirects: verifies JAL/JALR/taken-branch targets reach IF.
// Optional event counters are built only when CFM_COUNTERS_EN is defined.
module control_flow_monitor #(
  parameter int XLEN  = 32,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode_i,
  input  logic             stall_i,
  input  logic [1:0]       pc_next_sel_i,
  input  logic [XLEN-1:0]  pc_reg_ex_i,
  input  logic [XLEN-1:0]  pc_reg_if_i,
  input  logic [XLEN-1:0]  immediate_extended_ex_i,
  input  logic [XLEN-1:0]  rs1_data_ex_i,
  input  logic             branch_taken_ex_i,
  output logic             err_o,
  output logic [2:0]       err_code_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] check_count_o
);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [6:0]      r_ex_op;
  logic            r_err;
  logic [2:0]      r_err_code;
  logic            r_pend_valid  [LAT];
  logic [XLEN-1:0] r_pend_target [LAT];
  logic [2:0]      r_pend_code   [LAT];

  logic            w_in_valid  [LAT];
  logic [XLEN-1:0] w_in_target [LAT];
  logic [2:0]      w_in_code   [LAT];

  logic            w_is_jal, w_is_jalr, w_is_br, w_redirect, w_c1;
  logic [XLEN-1:0] w_sum_pc, w_sum_rs1;
  logic            w_cap_valid;
  logic [XLEN-1:0] w_cap_target;
  logic [2:0]      w_cap_code;
  logic            w_cmp_valid, w_mismatch, w_any_err;
  logic [2:0]      w_new_code;

  assign w_is_jal   = (r_ex_op == OP_JAL);
  assign w_is_jalr  = (r_ex_op == OP_JALR);
  assign w_is_br    = (r_ex_op == OP_BR);
  assign w_redirect = w_is_jal | w_is_jalr | (w_is_br & branch_taken_ex_i);

  // The instruction following a JALR in ID must be steered by the core's redirect select.
  assign w_c1 = w_is_jalr && ((opcode_i == OP_JAL) || (opcode_i == OP_BR)) &&
                (pc_next_sel_i != 2'b11);

  assign w_sum_pc  = pc_reg_ex_i + immediate_extended_ex_i;
  assign w_sum_rs1 = rs1_data_ex_i + immediate_extended_ex_i;

  always_comb begin
    w_cap_valid  = 1'b0;
    w_cap_target = w_sum_pc;
    w_cap_code   = 3'd0;
    if (!stall_i) begin
      if (w_is_jal) begin
        w_cap_valid = 1'b1;
        w_cap_code  = 3'd2;
      end else if (w_is_jalr) begin
        w_cap_valid  = 1'b1;
        w_cap_target = {w_sum_rs1[XLEN-1:1], 1'b0};
        w_cap_code   = 3'd3;
      end else if (w_is_br && branch_taken_ex_i) begin
        w_cap_valid = 1'b1;
        w_cap_code  = 3'd4;
      end
    end
  end

  // Pending pipeline: stage 0 takes the fresh capture, deeper stages shift from their predecessor.
  generate
    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign w_in_valid[gi]  = w_cap_valid;
        assign w_in_target[gi] = w_cap_target;
        assign w_in_code[gi]   = w_cap_code;
      end else begin : g_tail
        assign w_in_valid[gi]  = r_pend_valid[gi-1];
        assign w_in_target[gi] = r_pend_target[gi-1];
        assign w_in_code[gi]   = r_pend_code[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        r_pend_valid[i]  <= 1'b0;
        r_pend_target[i] <= '0;
        r_pend_code[i]   <= 3'd0;
      end
    end else if (!stall_i) begin
      for (int i = 0; i < LAT; i++) begin
        r_pend_valid[i]  <= w_in_valid[i];
        r_pend_target[i] <= w_in_target[i];
        r_pend_code[i]   <= w_in_code[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_op <= 7'd0;
    end else if (!stall_i) begin
      r_ex_op <= w_redirect ? 7'd0 : opcode_i;
    end
  end

  assign w_cmp_valid = !stall_i && r_pend_valid[LAT-1];
  assign w_mismatch  = w_cmp_valid && (r_pend_target[LAT-1] != pc_reg_if_i);
  assign w_any_err   = w_c1 | w_mismatch;
  assign w_new_code  = w_c1 ? 3'd1 : r_pend_code[LAT-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err      <= 1'b0;
      r_err_code <= 3'd0;
    end else if (w_any_err) begin
      r_err <= 1'b1;
      if (!r_err) begin
        r_err_code <= w_new_code;
      end
    end
  end

  assign err_o      = r_err;
  assign err_code_o = r_err_code;

`ifdef CFM_COUNTERS_EN
  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_err_cnt, r_chk_cnt;
  logic [1:0]       w_err_inc;
  logic [CNT_W:0]   w_err_sum;

  // A C1 violation and a target mismatch can land together, so the error count may step by 2.
  assign w_err_inc = {1'b0, w_c1} + {1'b0, w_mismatch};
  assign w_err_sum = {1'b0, r_err_cnt} + {{(CNT_W-1){1'b0}}, w_err_inc};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_cnt <= '0;
      r_chk_cnt <= '0;
    end else begin
      r_err_cnt <= (w_err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_err_sum[CNT_W-1:0];
      if (w_cmp_valid && (r_chk_cnt != {CNT_W{1'b1}})) begin
        r_chk_cnt <= r_chk_cnt + 1'b1;
      end
    end
  end

  assign err_count_o   = r_err_cnt;
  assign check_count_o = r_chk_cnt;
`else
  assign err_count_o   = '0;
  assign check_count_o = '0;
`endif

endmodule

// File: tb/tb_control_flow_monitor.sv
// Scoreboard bench: each driven cycle queues the outputs expected after its clock edge.
module tb_control_flow_monitor;

  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] NOP  = 7'b0010011;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode_i;
  logic        stall_i;
  logic [1:0]  pc_next_sel_i;
  logic [31:0] pc_reg_ex_i, pc_reg_if_i, immediate_extended_ex_i, rs1_data_ex_i;
  logic        branch_taken_ex_i;

  logic        a_err, b_err;
  logic [2:0]  a_code, b_code;
  logic [15:0] a_ecnt, a_ccnt;
  logic [1:0]  b_ecnt, b_ccnt;

  always #5 clk = ~clk;

  control_flow_monitor #(.XLEN(32), .LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .stall_i(stall_i),
    .pc_next_sel_i(pc_next_sel_i), .pc_reg_ex_i(pc_reg_ex_i), .pc_reg_if_i(pc_reg_if_i),
    .immediate_extended_ex_i(immediate_extended_ex_i), .rs1_data_ex_i(rs1_data_ex_i),
    .branch_taken_ex_i(branch_taken_ex_i), .err_o(a_err), .err_code_o(a_code),
    .err_count_o(a_ecnt), .check_count_o(a_ccnt)
  );

  control_flow_monitor #(.XLEN(32), .LAT(2), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .stall_i(stall_i),
    .pc_next_sel_i(pc_next_sel_i), .pc_reg_ex_i(pc_reg_ex_i), .pc_reg_if_i(pc_reg_if_i),
    .immediate_extended_ex_i(immediate_extended_ex_i), .rs1_data_ex_i(rs1_data_ex_i),
    .branch_taken_ex_i(branch_taken_ex_i), .err_o(b_err), .err_code_o(b_code),
    .err_count_o(b_ecnt), .check_count_o(b_ccnt)
  );

  typedef struct {
    int id;
    bit on_b;
    int e_err;
    int e_code;
    int e_ecnt;
    int e_ccnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_step   = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counter outputs are tied to zero unless the counter feature is built in.
  function automatic int cnt_exp(input int v);
    int r;
    r = v;
`ifndef CFM_COUNTERS_EN
    r = 0;
`endif
    return r;
  endfunction

  task automatic cyc(input bit rst, input logic [6:0] op, input bit st, input logic [1:0] ps,
                     input logic [31:0] pex, input logic [31:0] im, input logic [31:0] r1,
                     input bit tk, input logic [31:0] pif, input bit on_b,
                     input int ee, input int ec, input int en, input int cn);
    exp_t e;
    reset = rst; opcode_i = op; stall_i = st; pc_next_sel_i = ps;
    pc_reg_ex_i = pex; immediate_extended_ex_i = im; rs1_data_ex_i = r1;
    branch_taken_ex_i = tk; pc_reg_if_i = pif;
    e.id = n_step; e.on_b = on_b; e.e_err = ee; e.e_code = ec;
    e.e_ecnt = cnt_exp(en); e.e_ccnt = cnt_exp(cn);
    n_step++;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (!e.on_b) begin
        check_value($sformatf("s%0d_a_err", e.id), {31'b0, a_err}, e.e_err);
        check_value($sformatf("s%0d_a_code", e.id), {29'b0, a_code}, e.e_code);
        check_value($sformatf("s%0d_a_ecnt", e.id), {16'b0, a_ecnt}, e.e_ecnt);
        check_value($sformatf("s%0d_a_ccnt", e.id), {16'b0, a_ccnt}, e.e_ccnt);
        $display("step %0d dut_a err=%0d code=%0d ecnt=%0d ccnt=%0d", e.id, a_err, a_code, a_ecnt, a_ccnt);
      end else begin
        check_value($sformatf("s%0d_b_err", e.id), {31'b0, b_err}, e.e_err);
        check_value($sformatf("s%0d_b_code", e.id), {29'b0, b_code}, e.e_code);
        check_value($sformatf("s%0d_b_ecnt", e.id), {30'b0, b_ecnt}, e.e_ecnt);
        check_value($sformatf("s%0d_b_ccnt", e.id), {30'b0, b_ccnt}, e.e_ccnt);
        $display("step %0d dut_b err=%0d code=%0d ecnt=%0d ccnt=%0d", e.id, b_err, b_code, b_ecnt, b_ccnt);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int n;
    // LAT=1: JAL target, wrap-around, JALR good and bad targets
    cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0);
    cyc(0, JAL, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 'h100, 'h20, 0, 0, 0, 0,    0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h120, 0,       0, 0, 0, 1);
    cyc(0, JAL, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 1);
    cyc(0, NOP, 0, 0, 'hFFFFFFF0, 'h20, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h10, 0,        0, 0, 0, 2);
    cyc(0, JALR, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 2);
    cyc(0, NOP, 0, 0, 0, 'h10, 'h2001, 0, 0, 0,   0, 0, 0, 2);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h2010, 0,      0, 0, 0, 3);
    cyc(0, JALR, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 3);
    cyc(0, NOP, 0, 0, 0, 'h10, 'h2001, 0, 0, 0,   0, 0, 0, 3);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h2011, 0,      1, 3, 1, 4);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0,           1, 3, 1, 4);

    // C1 violation, then squash of the JAL that followed the JALR
    cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0);
    cyc(0, JALR, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0);
    cyc(0, JAL, 0, 2'b01, 0, 0, 'h100, 0, 0, 0,   1, 1, 1, 0);
    cyc(0, NOP, 0, 0, 'h500, 'h4, 0, 0, 'h100, 0, 1, 1, 1, 1);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'hDEAD, 0,      1, 1, 1, 1);
    cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0);
    cyc(0, JALR, 0, 0, 0, 0, 0, 0, 0, 0,          0, 0, 0, 0);
    cyc(0, JAL, 0, 2'b11, 0, 0, 'h100, 0, 0, 0,   0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 'h500, 'h4, 0, 0, 'h100, 0, 0, 0, 0, 1);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h999, 0,       0, 0, 0, 1);

    // Branches: not taken (no check), taken with negative offset, taken mismatch
    cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0);
    cyc(0, BR, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 'h40, 'hFFFFFFF0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, BR, 0, 0, 0, 0, 0, 0, 'h77, 0,         0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 'h40, 'hFFFFFFF0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, BR, 0, 0, 0, 0, 0, 0, 'h30, 0,         0, 0, 0, 1);
    cyc(0, NOP, 0, 0, 'h40, 'hFFFFFFF0, 0, 1, 0, 0, 0, 0, 0, 1);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h34, 0,        1, 4, 1, 2);

    // LAT=2: stalls freeze the pending entry; compare lands on the second live cycle
    cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 0);
    cyc(0, JAL, 0, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 'h200, 'h8, 0, 0, 0, 1,     0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(0, NOP, 1, 0, 0, 0, 0, 0, 'h999, 1,     0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h999, 1,       0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h208, 1,       0, 0, 0, 1);
    // Reset during a stall drops the in-flight check
    cyc(0, JAL, 0, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 1);
    cyc(0, NOP, 0, 0, 'h300, 0, 0, 0, 0, 1,       0, 0, 0, 1);
    cyc(0, NOP, 1, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 1);
    cyc(1, NOP, 1, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h123, 1,       0, 0, 0, 0);
    cyc(0, NOP, 0, 0, 0, 0, 0, 0, 'h123, 1,       0, 0, 0, 0);

    // CNT_W=2: five JAL mismatches saturate both counters at 3, first code kept
    cyc(1, NOP, 0, 0, 0, 0, 0, 0, 0, 1,           0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      n = (i >= 3) ? (i - 1) / 2 : 0;
      cyc(0, ((i % 2 == 0) && (i < 10)) ? JAL : NOP, 0, 0, 0, 'h40, 0, 0, 'h44, 1,
          (n > 0) ? 1 : 0, (n > 0) ? 2 : 0, (n > 3) ? 3 : n, (n > 3) ? 3 : n);
    end

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
